mem_port_arbiter: RTL and testbench

- Shares the single byte-wide external RAM port between the instruction-fetch stage and the MEM stage; the MEM stage sits downstream of the EX/MEM pipeline register.
- Sequences each 8/16/32-bit access as consecutive little-endian byte transfers.
- Returns a one-cycle ack to the granted requester. The pipeline stall logic uses `busy` and the acks to freeze the IF and MEM stages.

---
 rtl/riscv_defs.sv | 34 +++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// Shared definitions for the memory-port arbiter: access lengths, arbiter
// state encoding, requester ownership and a zero word constant.
package riscv_defs;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StAck
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Number of byte transfers for a mem_len code; codes 2 and 3 are both word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    unique case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-requester picker for the RAM port.
// Build option: define MEM_ARB_FAIR_EN for round-robin on ties; otherwise mem
// always beats IF.
module mem_arb_pick
  import riscv_defs::*;
(
  input  logic   if_req_i,
  input  logic   mem_req_i,
  input  owner_e last_i,
  output logic   grant_o,
  output owner_e owner_o
);

  // Pick the owner of the next access from the pending requests.
  always_comb begin
    grant_o = if_req_i | mem_req_i;
`ifdef MEM_ARB_FAIR_EN
    if (if_req_i && mem_req_i) begin
      owner_o = (last_i == OWN_IF) ? OWN_MEM : OWN_IF;
    end else begin
      owner_o = mem_req_i ? OWN_MEM : OWN_IF;
    end
`else
    owner_o = mem_req_i ? OWN_MEM : OWN_IF;
`endif
  end

`ifndef MEM_ARB_FAIR_EN
  // Last-grant history only matters for round-robin.
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the byte-wide RAM port between instruction fetch and the MEM stage,
// splitting 8/16/32-bit accesses into little-endian byte transfers.
// Build option: MEM_ARB_FAIR_EN selects round-robin tie-breaking (see mem_arb_pick).
module mem_port_arbiter
  import riscv_defs::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ack,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, n_q, n_d;
  logic              we_q, we_d;
  owner_e            owner_q, owner_d, last_q, last_d, pick_owner;
  logic [ADDR_W-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
  logic [31:0]       wdata_q, wdata_d, result_q, result_d;
  logic [31:0]       if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic              ram_wr_q, ram_wr_d, if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic              busy_q, busy_d, grant;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [ADDR_W-1:0] next_addr;
  logic [1:0]        rd_lane, wr_lane;
  logic [31:0]       cap_word;

  mem_arb_pick u_pick (
    .if_req_i  (if_req),
    .mem_req_i (mem_req),
    .last_i    (last_q),
    .grant_o   (grant),
    .owner_o   (pick_owner)
  );

  // Byte arriving now belongs to the address issued in the previous cycle.
  assign rd_lane   = 2'(cnt_q - 3'd1);
  assign wr_lane   = 2'(cnt_q + 3'd1);
  assign cap_word  = result_q | (32'(ram_din) << {rd_lane, 3'b000});
  assign next_addr = base_q + ADDR_W'(cnt_q + 3'd1);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    we_d        = we_q;
    owner_d     = owner_q;
    last_d      = last_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    result_d    = result_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_dout_d  = ram_dout_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d  = pick_owner;
          last_d   = pick_owner;
          cnt_d    = 3'd0;
          result_d = ZeroWord;
          if (pick_owner == OWN_MEM) begin
            base_d  = mem_addr;
            n_d     = len_bytes(mem_len);
            we_d    = mem_we;
            wdata_d = mem_wdata;
          end else begin
            base_d  = if_addr;
            n_d     = 3'd4;
            we_d    = 1'b0;
            wdata_d = ZeroWord;
          end
          ram_addr_d = base_d;
          ram_wr_d   = we_d;
          ram_dout_d = wdata_d[7:0];
          state_d    = we_d ? StWrite : StRead;
        end
      end
      StRead: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q != 3'd0) result_d = cap_word;
        if (cnt_q + 3'd1 < n_q) ram_addr_d = next_addr;
        if (cnt_q == n_q) begin
          state_d = StAck;
          if (owner_q == OWN_MEM) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = cap_word;
          end else begin
            if_ack_d  = 1'b1;
            if_data_d = cap_word;
          end
        end
      end
      StWrite: begin
        if (cnt_q + 3'd1 < n_q) begin
          cnt_d      = cnt_q + 3'd1;
          ram_addr_d = next_addr;
          ram_wr_d   = 1'b1;
          ram_dout_d = 8'(wdata_q >> {wr_lane, 3'b000});
        end else begin
          state_d = StAck;
          if (owner_q == OWN_MEM) mem_ack_d = 1'b1;
          else                    if_ack_d  = 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      we_q        <= 1'b0;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      base_q      <= '0;
      wdata_q     <= ZeroWord;
      result_q    <= ZeroWord;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= 8'h00;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_data_q   <= ZeroWord;
      mem_rdata_q <= ZeroWord;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      result_q    <= result_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_dout_q  <= ram_dout_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;
  assign if_ack    = if_ack_q;
  assign if_data   = if_data_q;
  assign mem_ack   = mem_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide RAM model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_len = 2'd0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;
  logic        busy;
  logic        ram_clr = 1'b1;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_data   (if_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_len   (mem_len),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ram_addr  (ram_addr),
    .ram_wr    (ram_wr),
    .ram_dout  (ram_dout),
    .ram_din   (ram_din),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM model: preset contents plus a written-byte overlay, one-cycle read latency.
  logic [7:0] wr_val [0:16383];
  logic       wr_vld [0:16383];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      32'h104: return 8'h93;
      32'h105: return 8'h05;
      32'h106: return 8'h15;
      32'h107: return 8'h00;
      32'h30:  return 8'h80;
      32'h31:  return 8'h7F;
      32'h32:  return 8'h00;
      32'h33:  return 8'hFF;
      32'hFFFF_FFFF: return 8'h11;
      32'h0:   return 8'h22;
      32'h1:   return 8'h33;
      32'h2:   return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int k = 0; k < 16384; k++) wr_vld[k] <= 1'b0;
    end else begin
      ram_din <= wr_vld[ram_addr[13:0]] ? wr_val[ram_addr[13:0]] : init_byte(ram_addr);
      if (ram_wr) begin
        wr_val[ram_addr[13:0]] <= ram_dout;
        wr_vld[ram_addr[13:0]] <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a tie to completion, dropping each request in its ack cycle.
  task automatic run_both(input int budget);
    logic got_if;
    logic got_mem;
    got_if  = 1'b0;
    got_mem = 1'b0;
    for (int k = 0; k < budget && !(got_if && got_mem); k++) begin
      tick();
      if (if_ack)  begin got_if  = 1'b1; if_req  = 1'b0; end
      if (mem_ack) begin got_mem = 1'b1; mem_req = 1'b0; end
    end
    chk("tie_if_acked", 32'(got_if), 32'd1);
    chk("tie_mem_acked", 32'(got_mem), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_wrap [4];
    exp_wrap[0] = 32'hFFFF_FFFF;
    exp_wrap[1] = 32'h0;
    exp_wrap[2] = 32'h1;
    exp_wrap[3] = 32'h2;

    // Reset values
    tick();
    tick();
    ram_clr = 1'b0;
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    chk("rst_if_ack", 32'(if_ack), 32'd0);
    chk("rst_mem_ack", 32'(mem_ack), 32'd0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Word fetch at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fetch_addr", ram_addr, 32'h100 + i);
      chk("fetch_busy", 32'(busy), 32'd1);
      chk("fetch_wr", 32'(ram_wr), 32'd0);
    end
    tick();
    chk("fetch_ack_early", 32'(if_ack), 32'd0);
    tick();
    chk("fetch_ack", 32'(if_ack), 32'd1);
    chk("fetch_data", if_data, 32'h0010_0513);
    chk("fetch_busy_ack", 32'(busy), 32'd1);
    tick();
    if_req = 1'b0;
    chk("fetch_ack_gone", 32'(if_ack), 32'd0);
    chk("fetch_idle", 32'(busy), 32'd0);

    // Tie after an IF grant: mem word read served first in both builds
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd2; mem_addr = 32'h30;
    tick();
    chk("tie1_first_addr", ram_addr, 32'h30);
    for (int i = 0; i < 5; i++) tick();
    chk("tie1_mem_ack", 32'(mem_ack), 32'd1);
    chk("tie1_if_ack", 32'(if_ack), 32'd0);
    chk("tie1_mem_rdata", mem_rdata, 32'hFF00_7F80);
    tick();
    mem_req = 1'b0;
    chk("tie1_gap_idle", 32'(busy), 32'd0);
    tick();
    chk("tie1_if_addr", ram_addr, 32'h104);
    chk("tie1_if_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("tie1_if_ack_late", 32'(if_ack), 32'd1);
    chk("tie1_if_data", if_data, 32'h0015_0593);
    tick();
    if_req = 1'b0;

    // Halfword store at 0x2001
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1;
    mem_addr = 32'h2001; mem_wdata = 32'hAABB_CCDD;
    tick();
    chk("st_wr0", 32'(ram_wr), 32'd1);
    chk("st_addr0", ram_addr, 32'h2001);
    chk("st_dout0", 32'(ram_dout), 32'hDD);
    tick();
    chk("st_wr1", 32'(ram_wr), 32'd1);
    chk("st_addr1", ram_addr, 32'h2002);
    chk("st_dout1", 32'(ram_dout), 32'hCC);
    chk("st_ack_early", 32'(mem_ack), 32'd0);
    tick();
    chk("st_ack", 32'(mem_ack), 32'd1);
    chk("st_wr_off_ack", 32'(ram_wr), 32'd0);
    tick();
    mem_req = 1'b0; mem_we = 1'b0;
    chk("st_wr_off_after", 32'(ram_wr), 32'd0);
    chk("st_idle", 32'(busy), 32'd0);

    // Tie after a mem grant: round-robin picks IF, fixed priority picks mem
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h30;
    tick();
`ifdef MEM_ARB_FAIR_EN
    chk("tie2_first_addr", ram_addr, 32'h100);
`else
    chk("tie2_first_addr", ram_addr, 32'h30);
`endif
    run_both(40);
    tick();
    chk("tie2_if_data", if_data, 32'h0010_0513);
    chk("tie2_mem_rdata", mem_rdata, 32'h0000_0080);

    // Byte load from 0x30
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h30;
    tick();
    chk("lb_addr", ram_addr, 32'h30);
    tick();
    chk("lb_ack_early", 32'(mem_ack), 32'd0);
    tick();
    chk("lb_ack", 32'(mem_ack), 32'd1);
    chk("lb_rdata", mem_rdata, 32'h0000_0080);
    chk("lb_if_data_held", if_data, 32'h0010_0513);
    tick();
    mem_req = 1'b0;

    // Halfword load reads back the stored bytes
    mem_req = 1'b1; mem_len = 2'd1; mem_addr = 32'h2001;
    for (int i = 0; i < 3; i++) tick();
    chk("lh_ack_early", 32'(mem_ack), 32'd0);
    tick();
    chk("lh_ack", 32'(mem_ack), 32'd1);
    chk("lh_rdata", mem_rdata, 32'h0000_CCDD);
    tick();
    mem_req = 1'b0;

    // Word fetch wrapping past the top of the address space
    if_req = 1'b1; if_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wrap_addr", ram_addr, exp_wrap[i]);
    end
    tick();
    tick();
    chk("wrap_ack", 32'(if_ack), 32'd1);
    chk("wrap_data", if_data, 32'h4433_2211);
    tick();
    if_req = 1'b0;

    // Reset during the second byte of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2;
    mem_addr = 32'h40; mem_wdata = 32'h1234_5678;
    tick();
    chk("rs_addr0", ram_addr, 32'h40);
    chk("rs_dout0", 32'(ram_dout), 32'h78);
    tick();
    chk("rs_addr1", ram_addr, 32'h41);
    chk("rs_dout1", 32'(ram_dout), 32'h56);
    rst = 1'b1;
    tick();
    chk("rs_wr_off", 32'(ram_wr), 32'd0);
    chk("rs_busy_off", 32'(busy), 32'd0);
    chk("rs_no_ack", 32'(mem_ack), 32'd0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    tick();
    chk("rs_still_no_ack", 32'(mem_ack), 32'd0);
    chk("rs_still_idle", 32'(busy), 32'd0);
    mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'h40;
    tick();
    chk("rs_fresh_addr", ram_addr, 32'h40);
    tick();
    tick();
    chk("rs_fresh_ack", 32'(mem_ack), 32'd1);
    chk("rs_fresh_rdata", mem_rdata, 32'h0000_0078);
    tick();
    mem_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
